// File: rtl/snn_ser_pkg.sv
// Shared types and sizing helpers for the SNN output serializer.
// SNN_SER_CHECKSUM_EN appends an XOR checksum byte to every frame.
package snn_ser_pkg;

    localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
    // header, seq and the three spike vectors precede the membrane bytes
    localparam int unsigned HDR_BYTES      = 5;

`ifdef SNN_SER_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] l1;
        logic [7:0] l2;
        logic [7:0] out_l;
    } spikes_t;

    function automatic int unsigned memb_bytes(input int unsigned n, input int unsigned w);
        return (n * w + 7) / 8;
    endfunction

    function automatic int unsigned frame_len(input int unsigned n, input int unsigned w,
                                              input bit chk);
        return HDR_BYTES + memb_bytes(n, w) + (chk ? 1 : 0);
    endfunction

    function automatic int unsigned byte_idx_width(input int unsigned len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/snn_output_serializer.sv
// Captures one SNN result snapshot per data_ready and streams it as a byte frame.
// Optional checksum byte enabled by SNN_SER_CHECKSUM_EN.
module snn_output_serializer
    import snn_ser_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 24,
    parameter int unsigned MP_WIDTH    = 5,
    parameter logic [7:0]  HEADER_BYTE = HEADER_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            data_ready,
    input  logic [NUM_NEURONS*MP_WIDTH-1:0] membrane_potential_in,
    input  logic [7:0]                      spikes_layer1,
    input  logic [7:0]                      spikes_layer2,
    input  logic [7:0]                      spikes_out,
    output logic [7:0]                      out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            overflow,
    input  logic                            clear_overflow
);

    localparam int unsigned MEMB_BYTES = memb_bytes(NUM_NEURONS, MP_WIDTH);
    localparam int unsigned MEMB_W     = MEMB_BYTES * 8;
    localparam int unsigned FRAME_LEN  = frame_len(NUM_NEURONS, MP_WIDTH, CHECKSUM_EN);
    localparam int unsigned IDX_W      = byte_idx_width(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] MEMB_BASE = IDX_W'(HDR_BYTES);

    state_t              state, state_d;
    logic [IDX_W-1:0]    byte_idx, idx_d, nxt_idx;
    logic [7:0]          seq, seq_d;
    logic [7:0]          data_d, next_byte;
    logic                valid_d, busy_d, done_d, ovf_d, ovf_set;
    logic                capture, accept, last_accept, snap;
    spikes_t             sh_spikes, spikes_d;
    logic [MEMB_W-1:0]   sh_memb, memb_d;
`ifdef SNN_SER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    // State, shadow snapshot and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_idx   <= '0;
            seq        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            sh_spikes  <= '0;
            sh_memb    <= '0;
`ifdef SNN_SER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state      <= state_d;
            byte_idx   <= idx_d;
            seq        <= seq_d;
            out_data   <= data_d;
            out_valid  <= valid_d;
            busy       <= busy_d;
            frame_done <= done_d;
            overflow   <= ovf_d;
            sh_spikes  <= spikes_d;
            sh_memb    <= memb_d;
`ifdef SNN_SER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    // Next-state, byte selection and overflow logic
    always_comb begin
        state_d   = state;
        idx_d     = byte_idx;
        seq_d     = seq;
        data_d    = out_data;
        valid_d   = out_valid;
        done_d    = 1'b0;
        ovf_set   = 1'b0;
        capture   = 1'b0;
        spikes_d  = sh_spikes;
        memb_d    = sh_memb;

        accept      = out_valid & out_ready;
        last_accept = accept & (byte_idx == LAST_IDX);
        snap        = enable & data_ready;

        // Byte that follows the one currently presented
        nxt_idx   = byte_idx + IDX_W'(1);
        next_byte = 8'(sh_memb >> {nxt_idx - MEMB_BASE, 3'b000});
        if (nxt_idx == IDX_W'(1))      next_byte = seq;
        else if (nxt_idx == IDX_W'(2)) next_byte = sh_spikes.l1;
        else if (nxt_idx == IDX_W'(3)) next_byte = sh_spikes.l2;
        else if (nxt_idx == IDX_W'(4)) next_byte = sh_spikes.out_l;
`ifdef SNN_SER_CHECKSUM_EN
        chk_d = chk_q;
        if (nxt_idx == LAST_IDX) next_byte = chk_q ^ out_data;
`endif

        case (state)
            IDLE: capture = snap;
            SEND: begin
                if (last_accept) begin
                    done_d = 1'b1;
                    seq_d  = seq + 8'd1;
                    if (snap) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else if (accept) begin
                    idx_d  = nxt_idx;
                    data_d = next_byte;
`ifdef SNN_SER_CHECKSUM_EN
                    chk_d  = chk_q ^ out_data;
`endif
                end
                ovf_set = snap & ~last_accept;
            end
            default: state_d = IDLE;
        endcase

        // A capture at the end of a frame chains straight into the next header
        if (capture) begin
            state_d  = SEND;
            idx_d    = '0;
            data_d   = HEADER_BYTE;
            valid_d  = 1'b1;
            spikes_d = '{l1: spikes_layer1, l2: spikes_layer2, out_l: spikes_out};
            memb_d   = MEMB_W'(membrane_potential_in);
`ifdef SNN_SER_CHECKSUM_EN
            chk_d    = '0;
`endif
        end

        ovf_d  = (overflow & ~clear_overflow) | ovf_set;
        busy_d = (state_d == SEND);
    end

endmodule

// File: tb/tb_snn_output_serializer.sv
// Directed self-checking bench for snn_output_serializer (default parameters).
module tb_snn_output_serializer;

    localparam int MPB = 120;
`ifdef SNN_SER_CHECKSUM_EN
    localparam int FLEN = 21;
`else
    localparam int FLEN = 20;
`endif

    logic           clk = 1'b0;
    logic           reset, enable, data_ready, out_ready, clear_overflow;
    logic [MPB-1:0] membrane_potential_in;
    logic [7:0]     spikes_layer1, spikes_layer2, spikes_out;
    logic [7:0]     out_data;
    logic           out_valid, busy, frame_done, overflow;

    logic [7:0] rx   [0:31];
    logic [7:0] expf [0:31];
    logic [7:0] exp_seq;
    int tests = 0;
    int fails = 0;
    int nb, dc, da, he;

    always #5 clk = ~clk;

    snn_output_serializer dut (
        .clk(clk), .reset(reset), .enable(enable), .data_ready(data_ready),
        .membrane_potential_in(membrane_potential_in),
        .spikes_layer1(spikes_layer1), .spikes_layer2(spikes_layer2), .spikes_out(spikes_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    // Reference frame: header, seq, spikes, little-endian membrane bytes, XOR checksum
    task automatic build_exp(input logic [7:0] s, input logic [7:0] l1, input logic [7:0] l2,
                             input logic [7:0] o, input logic [MPB-1:0] m);
        logic [7:0] c;
        expf[0] = 8'hA5; expf[1] = s; expf[2] = l1; expf[3] = l2; expf[4] = o;
        for (int k = 0; k < 15; k++) expf[5+k] = 8'(m >> (8 * k));
        c = 8'h00;
        for (int i = 0; i < 20; i++) c = c ^ expf[i];
        expf[20] = c;
    endtask

    task automatic set_snap(input logic [7:0] l1, input logic [7:0] l2, input logic [7:0] o,
                            input logic [MPB-1:0] m);
        spikes_layer1 = l1; spikes_layer2 = l2; spikes_out = o; membrane_potential_in = m;
    endtask

    task automatic start_frame();
        data_ready = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
    endtask

    // Sink: accepts up to max_bytes, optional stall and data_ready injection
    task automatic get_frame(input int max_bytes, input int stall_at, input int stall_cycles,
                             input int dr_idx, input logic dr_clr,
                             output int nbytes, output int done_cnt, output int done_at,
                             output int hold_err);
        int stalls, cycles;
        logic [7:0] held;
        nbytes = 0; done_cnt = 0; done_at = -1; hold_err = 0;
        stalls = 0; cycles = 0; held = 8'h00;
        while (nbytes < max_bytes && cycles < 400) begin
            out_ready = 1'b1;
            if (out_valid) begin
                if (nbytes == stall_at && stalls < stall_cycles) begin
                    out_ready = 1'b0;
                    if (stalls == 0) held = out_data;
                    else if (out_data !== held) hold_err++;
                    stalls++;
                end else begin
                    if (stalls > 0 && nbytes == stall_at && out_data !== held) hold_err++;
                    rx[nbytes] = out_data;
                    if (nbytes == dr_idx) begin
                        data_ready = 1'b1;
                        clear_overflow = dr_clr;
                    end
                    nbytes++;
                end
            end else if (stalls > 0 && nbytes == stall_at) begin
                hold_err++;
            end
            @(posedge clk); #1;
            data_ready = 1'b0; clear_overflow = 1'b0; cycles++;
            if (frame_done) begin done_cnt++; done_at = nbytes; end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out_data, out_valid, busy, frame_done, overflow} !== 12'h000) begin
            fails++;
            $display("FAIL reset_state: got data=%02h v=%b b=%b d=%b o=%b expected all 0",
                     out_data, out_valid, busy, frame_done, overflow);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL idle_after_reset: got v=%b b=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_zero_frame();
        set_snap(8'h00, 8'h00, 8'h00, '0);
        start_frame();
        tests++;
        if ({out_valid, busy, out_data} !== {1'b1, 1'b1, 8'hA5}) begin
            fails++;
            $display("FAIL first_byte_latency: got v=%b b=%b data=%02h expected 1 1 a5",
                     out_valid, busy, out_data);
        end
        get_frame(FLEN, -1, 0, -1, 1'b0, nb, dc, da, he);
        build_exp(exp_seq, 8'h00, 8'h00, 8'h00, '0);
        tests++;
        if (nb !== FLEN) begin fails++; $display("FAIL zero_len: got %0d expected %0d", nb, FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            tests++;
            if (rx[i] !== expf[i]) begin
                fails++;
                $display("FAIL zero_byte%0d: got %02h expected %02h", i, rx[i], expf[i]);
            end
        end
        tests++;
        if (dc !== 1 || da !== FLEN) begin
            fails++;
            $display("FAIL zero_done: got count=%0d at=%0d expected 1 at %0d", dc, da, FLEN);
        end
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL zero_end_idle: got v=%b b=%b expected 0 0", out_valid, busy);
        end
        exp_seq++;
    endtask

    task automatic test_pattern_frame();
        set_snap(8'h81, 8'h00, 8'h0F, MPB'(8'h3C));
        start_frame();
        set_snap(8'hFF, 8'hFF, 8'hFF, '1);
        get_frame(FLEN, -1, 0, -1, 1'b0, nb, dc, da, he);
        build_exp(exp_seq, 8'h81, 8'h00, 8'h0F, MPB'(8'h3C));
        tests++;
        if (nb !== FLEN || dc !== 1) begin
            fails++;
            $display("FAIL pattern_len: got len=%0d done=%0d expected %0d 1", nb, dc, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            tests++;
            if (rx[i] !== expf[i]) begin
                fails++;
                $display("FAIL pattern_byte%0d: got %02h expected %02h", i, rx[i], expf[i]);
            end
        end
        exp_seq++;
    endtask

    task automatic test_backpressure();
        logic [MPB-1:0] m;
        m = '0;
        for (int k = 0; k < 15; k++) m = m | (MPB'(k + 1) << (8 * k));
        set_snap(8'h11, 8'h22, 8'h33, m);
        start_frame();
        get_frame(FLEN, 3, 5, -1, 1'b0, nb, dc, da, he);
        build_exp(exp_seq, 8'h11, 8'h22, 8'h33, m);
        tests++;
        if (he !== 0) begin fails++; $display("FAIL bp_hold: got %0d hold errors expected 0", he); end
        tests++;
        if (nb !== FLEN || dc !== 1 || da !== FLEN) begin
            fails++;
            $display("FAIL bp_len: got len=%0d done=%0d at=%0d expected %0d 1 %0d", nb, dc, da, FLEN, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            tests++;
            if (rx[i] !== expf[i]) begin
                fails++;
                $display("FAIL bp_byte%0d: got %02h expected %02h", i, rx[i], expf[i]);
            end
        end
        exp_seq++;
    endtask

    task automatic test_disabled();
        enable = 1'b0;
        start_frame();
        tests++;
        if ({out_valid, busy, overflow} !== 3'b000) begin
            fails++;
            $display("FAIL disabled_ignore: got v=%b b=%b o=%b expected 0 0 0", out_valid, busy, overflow);
        end
        enable = 1'b1;
    endtask

    task automatic test_overflow();
        // Mid-frame snapshot is dropped and flagged
        set_snap(8'h5A, 8'hC3, 8'h01, MPB'(16'hBEEF));
        start_frame();
        set_snap(8'hEE, 8'hEE, 8'hEE, '1);
        get_frame(FLEN, -1, 0, 7, 1'b0, nb, dc, da, he);
        build_exp(exp_seq, 8'h5A, 8'hC3, 8'h01, MPB'(16'hBEEF));
        for (int i = 0; i < FLEN; i++) begin
            tests++;
            if (rx[i] !== expf[i]) begin
                fails++;
                $display("FAIL ovf_byte%0d: got %02h expected %02h", i, rx[i], expf[i]);
            end
        end
        tests++;
        if (overflow !== 1'b1 || dc !== 1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL ovf_set: got o=%b done=%0d v=%b expected 1 1 0", overflow, dc, out_valid);
        end
        exp_seq++;
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", overflow); end

        // Clear and a new drop in the same cycle: the drop wins
        set_snap(8'h01, 8'h02, 8'h03, '0);
        start_frame();
        get_frame(FLEN, -1, 0, 7, 1'b1, nb, dc, da, he);
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        exp_seq++;
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;

        // Snapshot coinciding with last-byte acceptance chains a new frame
        set_snap(8'hA1, 8'hB2, 8'hC3, MPB'(24'h123456));
        start_frame();
        set_snap(8'h0D, 8'h0E, 8'h0F, {8'h99, 104'h0, 8'h77});
        get_frame(FLEN, -1, 0, FLEN - 1, 1'b0, nb, dc, da, he);
        build_exp(exp_seq, 8'hA1, 8'hB2, 8'hC3, MPB'(24'h123456));
        for (int i = 0; i < FLEN; i++) begin
            tests++;
            if (rx[i] !== expf[i]) begin
                fails++;
                $display("FAIL b2b_first_byte%0d: got %02h expected %02h", i, rx[i], expf[i]);
            end
        end
        tests++;
        if ({out_valid, busy, out_data, overflow} !== {1'b1, 1'b1, 8'hA5, 1'b0} || dc !== 1) begin
            fails++;
            $display("FAIL b2b_chain: got v=%b b=%b data=%02h o=%b done=%0d expected 1 1 a5 0 1",
                     out_valid, busy, out_data, overflow, dc);
        end
        exp_seq++;
        set_snap(8'h00, 8'h00, 8'h00, '0);
        get_frame(FLEN, -1, 0, -1, 1'b0, nb, dc, da, he);
        build_exp(exp_seq, 8'h0D, 8'h0E, 8'h0F, {8'h99, 104'h0, 8'h77});
        for (int i = 0; i < FLEN; i++) begin
            tests++;
            if (rx[i] !== expf[i]) begin
                fails++;
                $display("FAIL b2b_second_byte%0d: got %02h expected %02h", i, rx[i], expf[i]);
            end
        end
        exp_seq++;
    endtask

    task automatic test_reset_midframe();
        set_snap(8'h44, 8'h55, 8'h66, '1);
        start_frame();
        get_frame(10, -1, 0, -1, 1'b0, nb, dc, da, he);
        tests++;
        if (nb !== 10 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL midframe_progress: got len=%0d v=%b expected 10 1", nb, out_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++;
        if ({out_data, out_valid, busy, frame_done, overflow} !== 12'h000) begin
            fails++;
            $display("FAIL midframe_reset: got data=%02h v=%b b=%b d=%b o=%b expected all 0",
                     out_data, out_valid, busy, frame_done, overflow);
        end
        exp_seq = 8'h00;
        set_snap(8'h12, 8'h34, 8'h56, MPB'(8'h78));
        start_frame();
        get_frame(FLEN, -1, 0, -1, 1'b0, nb, dc, da, he);
        build_exp(exp_seq, 8'h12, 8'h34, 8'h56, MPB'(8'h78));
        tests++;
        if (nb !== FLEN || dc !== 1) begin
            fails++;
            $display("FAIL post_reset_len: got len=%0d done=%0d expected %0d 1", nb, dc, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            tests++;
            if (rx[i] !== expf[i]) begin
                fails++;
                $display("FAIL post_reset_byte%0d: got %02h expected %02h", i, rx[i], expf[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; data_ready = 1'b0; out_ready = 1'b1; clear_overflow = 1'b0;
        set_snap(8'h00, 8'h00, 8'h00, '0);
        exp_seq = 8'h00;
        test_reset();
        test_zero_frame();
        test_pattern_frame();
        test_backpressure();
        test_disabled();
        test_overflow();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
